// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_if
// Description : Operand / control / result bundle between the E stage and
//               the multiply-divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if;
    logic [31:0] A;        // rs operand (forwarded)
    logic [31:0] B;        // rt operand (forwarded)
    logic [3:0]  MDUOp;    // operation select
    logic        Start;    // qualifies mult/multu/div/divu
    logic        Busy;     // operation in flight
    logic [31:0] HI;       // architectural HI
    logic [31:0] LO;       // architectural LO
    logic [31:0] MDUOut;   // mfhi/mflo read value

    modport master (
        output A, B, MDUOp, Start,
        input  Busy, HI, LO, MDUOut
    );

    modport slave (
        input  A, B, MDUOp, Start,
        output Busy, HI, LO, MDUOut
    );
endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               Result is computed at issue, staged, and committed to HI/LO
//               on the last busy cycle so software-visible timing matches a
//               fixed-latency iterative unit.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_wr;   // cleared for divide-by-zero so HI/LO survive
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_op;
    logic        w_is_mul;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_ovf;
    logic [31:0] w_div_s_b;
    logic [31:0] w_div_u_b;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;

    assign w_is_op  = (bus.MDUOp >= c_OP_MULT) && (bus.MDUOp <= c_OP_DIVU);
    assign w_is_mul = (bus.MDUOp == c_OP_MULT) || (bus.MDUOp == c_OP_MULTU);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // -2^31 / -1 is replaced by -2^31 / 1, which yields the required wrapped
    // quotient 0x80000000 with remainder 0 and never evaluates an overflowing divide.
    // A zero divisor is replaced by 1 only to keep the divider defined; the
    // result is discarded through r_res_wr.
    assign w_div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign w_div_s_b = ((bus.B == 32'd0) || w_div_ovf) ? 32'd1 : bus.B;
    assign w_div_u_b = (bus.B == 32'd0) ? 32'd1 : bus.B;
    assign w_sa      = bus.A;
    assign w_sb      = w_div_s_b;
    assign w_sq      = w_sa / w_sb;
    assign w_sr      = w_sa % w_sb;
    assign w_uq      = bus.A / w_div_u_b;
    assign w_ur      = bus.A % w_div_u_b;

    // Select the result to stage for the issuing operation.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b1;
        case (bus.MDUOp)
            c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            c_OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_wr = (bus.B != 32'd0);
            end
            c_OP_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_res_wr = (bus.B != 32'd0);
            end
            default: w_res_wr = 1'b0;
        endcase
    end

    // Issue / count-down / commit state machine plus mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start && w_is_op) begin
                        r_res_hi <= w_res_hi;
                        r_res_lo <= w_res_lo;
                        r_res_wr <= w_res_wr;
                        r_cnt    <= w_is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end else if (!bus.Start && (bus.MDUOp == c_OP_MTHI)) begin
                        r_hi <= bus.A;
                    end else if (!bus.Start && (bus.MDUOp == c_OP_MTLO)) begin
                        r_lo <= bus.A;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (r_res_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy   = r_busy;
    assign bus.HI     = r_hi;
    assign bus.LO     = r_lo;
    assign bus.MDUOut = (bus.MDUOp == c_OP_MFHI) ? r_hi :
                        (bus.MDUOp == c_OP_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu: directed cases with literal
//               expectations plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic clk;
    logic reset;
    mdu_if bus ();

    mdu #(.MULT_CYCLES(c_MULT), .DIV_CYCLES(c_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {write_enable, hi, lo} computed from arithmetic rules.
    function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        logic [31:0]     ma, mb, q, r;
        ref_result = '0;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                ref_result = {1'b1, 64'(sp)};
            end
            4'd2: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                ref_result = {1'b1, 64'(up)};
            end
            4'd3: begin
                if (b != 0) begin
                    ma = a[31] ? -a : a;
                    mb = b[31] ? -b : b;
                    q  = ma / mb;
                    r  = ma % mb;
                    if (a[31] ^ b[31]) q = -q;
                    if (a[31]) r = -r;
                    ref_result = {1'b1, r, q};
                end
            end
            4'd4: begin
                if (b != 0) ref_result = {1'b1, a % b, a / b};
            end
            default: ref_result = '0;
        endcase
    endfunction

    // Reference model state: architectural HI/LO and remaining busy cycles.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;
    logic        m_valid = 1'b0;

    // Advance the reference model once per rising edge.
    always @(posedge clk) begin : p_model
        logic [64:0] rr;
        if (reset) begin
            m_hi    <= '0;
            m_lo    <= '0;
            m_left  <= 0;
            m_valid <= 1'b1;
        end else if (m_left > 0) begin
            if (m_left == 1 && m_pwr) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
            m_left <= m_left - 1;
        end else if (bus.Start && bus.MDUOp >= 4'd1 && bus.MDUOp <= 4'd4) begin
            rr     = ref_result(bus.MDUOp, bus.A, bus.B);
            m_pwr  <= rr[64];
            m_phi  <= rr[63:32];
            m_plo  <= rr[31:0];
            m_left <= (bus.MDUOp <= 4'd2) ? c_MULT : c_DIV;
        end else if (!bus.Start && bus.MDUOp == 4'd7) begin
            m_hi <= bus.A;
        end else if (!bus.Start && bus.MDUOp == 4'd8) begin
            m_lo <= bus.A;
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin : p_compare
        logic [31:0] exp_out;
        if (m_valid) begin
            exp_out = (bus.MDUOp == 4'd5) ? m_hi : (bus.MDUOp == 4'd6) ? m_lo : 32'd0;
            chk("cyc_busy", {31'd0, bus.Busy}, {31'd0, (m_left > 0)});
            chk("cyc_hi", bus.HI, m_hi);
            chk("cyc_lo", bus.LO, m_lo);
            chk("cyc_mduout", bus.MDUOut, exp_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and return the number of cycles Busy was seen high.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        bus.MDUOp = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0; bus.MDUOp = 4'd0;
        n = 0;
        while (bus.Busy && n < 40) begin
            n++;
            tick();
        end
        if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bus.A = '0; bus.B = '0; bus.MDUOp = '0; bus.Start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_hi", bus.HI, 32'd0);
        chk("reset_lo", bus.LO, 32'd0);

        // mult -2 * 3
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);

        // multu max * max, then mflo in first idle cycle
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
        chk("multu_lo", bus.LO, 32'h0000_0001);
        bus.MDUOp = 4'd6; #1;
        chk("b2b_mflo", bus.MDUOut, 32'h0000_0001);

        // div / divu -7, 2
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        chk("model_div_hi", m_hi, 32'hFFFF_FFFF);
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, n);
        chk("divu_lo", bus.LO, 32'h7FFF_FFFC);
        chk("divu_hi", bus.HI, 32'h0000_0001);

        // mthi / mtlo then divide by zero leaves them untouched
        bus.MDUOp = 4'd7; bus.A = 32'h1234_5678; tick();
        bus.MDUOp = 4'd8; bus.A = 32'h0000_0009; tick();
        run_op(4'd3, 32'd100, 32'd0, n);
        chk("div0_cycles", 32'(n), 32'd10);
        chk("div0_hi", bus.HI, 32'h1234_5678);
        chk("div0_lo", bus.LO, 32'h0000_0009);
        bus.MDUOp = 4'd5; #1;
        chk("mfhi_out", bus.MDUOut, 32'h1234_5678);

        // signed overflow wraps
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("ovf_lo", bus.LO, 32'h8000_0000);
        chk("ovf_hi", bus.HI, 32'h0000_0000);

        // mthi during busy cycle 2 is ignored
        bus.MDUOp = 4'd1; bus.A = 32'd3; bus.B = 32'd4; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0; bus.MDUOp = 4'd0;
        tick();
        bus.MDUOp = 4'd7; bus.A = 32'hDEAD_BEEF;
        tick();
        bus.MDUOp = 4'd0;
        n = 0;
        while (bus.Busy && n < 40) begin n++; tick(); end
        chk("busy_mthi_hi", bus.HI, 32'd0);
        chk("busy_mthi_lo", bus.LO, 32'd12);

        // reset during 4th busy cycle aborts divide
        bus.MDUOp = 4'd4; bus.A = 32'd1000; bus.B = 32'd7; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0; bus.MDUOp = 4'd0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_hi", bus.HI, 32'd0);
        chk("abort_lo", bus.LO, 32'd0);
        repeat (10) tick();
        chk("abort_hi_later", bus.HI, 32'd0);
        chk("abort_lo_later", bus.LO, 32'd0);

        // Start coincident with reset is ignored
        bus.MDUOp = 4'd1; bus.A = 32'd5; bus.B = 32'd5; bus.Start = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; bus.Start = 1'b0; bus.MDUOp = 4'd0;
        chk("start_rst_busy", {31'd0, bus.Busy}, 32'd0);

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) op = 4'($urandom_range(1, 8));
            bus.MDUOp = op;
            bus.Start = (op >= 4'd1 && op <= 4'd4) ? ($urandom_range(0, 3) != 0)
                                                   : ($urandom_range(0, 7) == 0);
            bus.A = $urandom();
            bus.B = $urandom();
            case ($urandom_range(0, 15))
                0: bus.B = 32'd0;
                1: begin bus.A = 32'h8000_0000; bus.B = 32'hFFFF_FFFF; end
                2: bus.B = 32'($urandom_range(1, 9));
                3: bus.B = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: ;
            endcase
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; bus.Start = 1'b0; bus.MDUOp = 4'd0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A  input  32  E-stage rs operand (forwarded value).
REQ-006 B  input  32  E-stage rt operand (forwarded value).
REQ-007 MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-008 Start  input  1  high in the cycle a mult/multu/div/divu sits in E; qualifies ops 1-4.
REQ-009 Busy  output  1  registered; high while an operation is in flight; consumed by the stall unit as E_MDU_Busy.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.
REQ-012 MDUOut  output  32  combinational read: HI when MDUOp=5, LO when MDUOp=6, else 0.

Function
REQ-013 States IDLE and BUSY; 4-bit down-counter cnt; result staging registers res_hi, res_lo.
REQ-014 IDLE, Start=1, MDUOp in 1..4: latch result into res_hi/res_lo, load cnt with MULT_CYCLES or DIV_CYCLES, go BUSY; Busy=1 from next cycle.
REQ-015 BUSY: cnt decrements each cycle; when cnt=1, write res_hi->HI and res_lo->LO at that edge, clear Busy, go IDLE.
REQ-016 Latency: Start in cycle T -> Busy high in cycles T+1..T+N exactly, N = op cycle count; new HI/LO visible from cycle T+N+1.
REQ-017 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit A*B.
REQ-018 div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; divu: unsigned quotient/remainder.
REQ-019 div/divu with B=0: full busy period runs; HI and LO left unchanged at completion.
REQ-020 div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap, no trap).
REQ-021 mthi (7): HI<=A at edge; mtlo (8): LO<=A at edge; only in IDLE and Start=0.
REQ-022 Start, mthi or mtlo arriving while BUSY: ignored; in-flight operation and its result unaffected (stall unit guarantees this does not occur; no error flag).
REQ-023 Start=1 with MDUOp outside 1..4, or MDUOp 1..4 with Start=0: no operation started.
REQ-024 MDUOut unaffected by Busy; reads current HI/LO, never staged result.
REQ-025 Back-to-back: Start may be accepted in the first IDLE cycle after completion; MDUOp 5/6 in that cycle reads the new HI/LO.

Reset
REQ-026 reset=1 at edge: HI=0, LO=0, Busy=0, cnt=0, staging registers=0, state IDLE; takes precedence over all ops.
REQ-027 reset asserted mid-operation: operation aborted, HI/LO=0, no result written afterwards.
REQ-028 Start coincident with reset: ignored; Busy=0 next cycle.

Verification
REQ-029 mult A=0xFFFFFFFE(-2), B=3, Start at T -> Busy high T+1..T+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 div A=0xFFFFFFF9(-7), B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu same operands -> LO=0x7FFFFFFC, HI=1.
REQ-032 mthi A=0x12345678, mtlo A=0x9, then div B=0 -> HI=0x12345678, LO=0x9 after 10 busy cycles; MDUOp=5 gives MDUOut=0x12345678.
REQ-033 div started, reset at 4th busy cycle -> Busy=0, HI=LO=0 next cycle, stay 0 for 10 further cycles.
REQ-034 Start with mthi pulse during busy cycle 2 -> HI reflects only the completed operation's result.
